// File: rtl/processor_unit.sv
// Serial 2x2 matrix-multiply engine: loads A (2x4) and B (4x2) bytes into a 16-entry RAM,
// runs one MAC per cycle, then streams C00,C01,C10,C11. Define SATURATE_EN for saturating output.
module processor_unit #(
  parameter int DW    = 8,
  parameter int ACC_W = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] data_in,
  input  logic          trigger,
  output logic          finished,
  output logic [DW-1:0] result
);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUT} state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic [ACC_W-1:0]        acc_q;
  logic [3:0][DW-1:0]      cbuf_q;
  logic                    finished_q;
  logic [DW-1:0]           result_q;
  logic [DW-1:0]           ram_q [16];

  logic                    ram_we;
  logic [3:0]              ram_waddr;
  logic [3:0]              a_addr;
  logic [3:0]              b_addr;
  logic [2*DW-1:0]         prod;
  logic [ACC_W-1:0]        mac_sum;
  logic [DW-1:0]           elem;

  // Storage only; contents are don't-care after reset, so no reset branch.
  assign ram_we    = ((state_q == IDLE) && trigger) || (state_q == LOAD);
  assign ram_waddr = (state_q == IDLE) ? 4'd0 : cnt_q;

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_waddr] <= data_in;
  end

  // cnt_q = {i, j, k[1:0]}: A[i][k] at 4i+k, B[k][j] at 8+2k+j.
  assign a_addr  = {1'b0, cnt_q[3], cnt_q[1:0]};
  assign b_addr  = {1'b1, cnt_q[1:0], cnt_q[2]};
  assign prod    = ram_q[a_addr] * ram_q[b_addr];
  assign mac_sum = acc_q + ACC_W'(prod);

`ifdef SATURATE_EN
  assign elem = (|mac_sum[ACC_W-1:DW]) ? {DW{1'b1}} : mac_sum[DW-1:0];
`else
  assign elem = mac_sum[DW-1:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      cbuf_q     <= '0;
      finished_q <= 1'b0;
      result_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          finished_q <= 1'b0;
          result_q   <= '0;
          cnt_q      <= '0;
          if (trigger) begin
            cnt_q   <= 4'd1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= COMPUTE;
        end
        COMPUTE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q[1:0] == 2'd3) begin
            cbuf_q[cnt_q[3:2]] <= elem;
            acc_q              <= '0;
          end else begin
            acc_q <= mac_sum;
          end
          if (cnt_q == 4'd15) state_q <= OUT;
        end
        OUT: begin
          finished_q <= 1'b1;
          result_q   <= cbuf_q[cnt_q[1:0]];
          cnt_q      <= cnt_q + 4'd1;
          // IDLE clears the outputs on the following edge, giving exactly four valid cycles.
          if (cnt_q == 4'd3) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign finished = finished_q;
  assign result   = result_q;

endmodule

// File: tb/tb_processor_unit.sv
// Table-driven bench for processor_unit: directed load vectors plus reset and trigger corner cases.
module tb_processor_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       trigger;
  logic [7:0] data_in;
  logic       finished;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [0:15][7:0] d;
    logic [0:3][7:0]  et;
    logic [0:3][7:0]  es;
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  processor_unit dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .trigger  (trigger),
    .finished (finished),
    .result   (result)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_of(input int n, input int idx);
`ifdef SATURATE_EN
    return tbl[n].es[idx];
`else
    return tbl[n].et[idx];
`endif
  endfunction

  // Edge e is the e-th rising edge after the trigger edge (e=0); outputs sampled 1ns after it.
  // mode: 0 trigger low after edge 0, 1 toggling, 2 held high.
  task automatic run_vec(input int n, input int mode);
    logic efin;
    for (int e = 0; e < 36; e++) begin
      data_in = (e < 16) ? tbl[n].d[e] : 8'h5A;
      trigger = (e == 0) ? 1'b1 : (mode == 2) ? 1'b1 : (mode == 1) ? e[0] : 1'b0;
      step();
      efin = (e >= 32);
      chk($sformatf("v%0d_m%0d_fin_e%0d", n, mode, e), {7'b0, finished}, {7'b0, efin});
      chk($sformatf("v%0d_m%0d_res_e%0d", n, mode, e), result,
          efin ? exp_of(n, e - 32) : 8'd0);
    end
  endtask

  task automatic idle_gap(input int cycles);
    trigger = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      data_in = 8'(c * 17 + 3);
      step();
      chk("idle_fin", {7'b0, finished}, 8'd0);
      chk("idle_res", result, 8'd0);
    end
  endtask

  initial begin
    tbl[0].d  = {8'd9, 8'd21, 8'd105, 8'd134, 8'd7, 8'd3, 8'd19, 8'd29,
                 8'd14, 8'd27, 8'd8, 8'd20, 8'd24, 8'd30, 8'd40, 8'd36};
    tbl[0].et = {8'd238, 8'd189, 8'd202, 8'd71};
    tbl[0].es = {8'd255, 8'd255, 8'd255, 8'd255};
    tbl[1].d  = {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0,
                 8'd5, 8'd6, 8'd7, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
    tbl[1].et = {8'd5, 8'd6, 8'd7, 8'd8};
    tbl[1].es = {8'd5, 8'd6, 8'd7, 8'd8};
    tbl[2].d  = '0;
    tbl[2].et = '0;
    tbl[2].es = '0;
    tbl[3].d  = '1;
    tbl[3].et = {8'd4, 8'd4, 8'd4, 8'd4};
    tbl[3].es = {8'd255, 8'd255, 8'd255, 8'd255};
    tbl[4].d  = {8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 8'd0, 8'd1, 8'd0,
                 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
    tbl[4].et = {8'd12, 8'd17, 8'd3, 8'd1};
    tbl[4].es = {8'd12, 8'd17, 8'd3, 8'd1};

    // Reset held for 100 ns with busy inputs.
    reset   = 1'b0;
    trigger = 1'b0;
    data_in = 8'd0;
    for (int t = 0; t < 10; t++) begin
      #10;
      trigger = ~trigger;
      data_in = 8'($urandom_range(0, 255));
      chk("rst_fin", {7'b0, finished}, 8'd0);
      chk("rst_res", result, 8'd0);
    end
    @(posedge clk);
    #1;
    trigger = 1'b0;
    reset   = 1'b1;
    idle_gap(3);

    // Table vectors, trigger low after the start edge.
    for (int n = 0; n < 5; n++) begin
      run_vec(n, 0);
      idle_gap(2);
    end

    // Trigger pulses during LOAD/COMPUTE/OUT must not disturb the run.
    run_vec(4, 1);
    idle_gap(2);
    run_vec(0, 1);
    idle_gap(2);

    // Trigger held high: the second load starts on the first edge after OUT.
    run_vec(0, 2);
    run_vec(4, 2);
    run_vec(1, 2);
    idle_gap(3);

    // Reset at edge 20 (mid-COMPUTE), then a fresh full load.
    for (int e = 0; e < 20; e++) begin
      data_in = (e < 16) ? tbl[3].d[e] : 8'h33;
      trigger = (e == 0);
      step();
      chk($sformatf("midc_fin_e%0d", e), {7'b0, finished}, 8'd0);
    end
    step();
    reset = 1'b0;
    #1;
    chk("midc_rst_fin", {7'b0, finished}, 8'd0);
    chk("midc_rst_res", result, 8'd0);
    step();
    step();
    reset = 1'b1;
    idle_gap(2);
    run_vec(0, 0);
    idle_gap(2);

    // Reset during OUT: finished must drop without waiting for a clock edge.
    for (int e = 0; e < 33; e++) begin
      data_in = (e < 16) ? tbl[1].d[e] : 8'h11;
      trigger = (e == 0);
      step();
    end
    chk("mido_fin_before", {7'b0, finished}, 8'd1);
    chk("mido_res_before", result, 8'd5);
    #2;
    reset = 1'b0;
    #1;
    chk("mido_async_fin", {7'b0, finished}, 8'd0);
    chk("mido_async_res", result, 8'd0);
    step();
    reset = 1'b1;
    idle_gap(2);
    run_vec(1, 0);
    idle_gap(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/processor_unit.md
Name: processor_unit

Overview:
- Small serial matrix-multiply engine.
- Loads 16 bytes from data_in into an internal 16×8 RAM.
- Computes the 2×2 product C = A×B:
  - A is 2×4, RAM[0..7], row-major.
  - B is 4×2, RAM[8..15], row-major.
- Streams the four C elements out on result, framed by finished.
- Sits between a byte-wide host source and a downstream byte-wide consumer.

Parameters:
- DW, 8, data/element width of data_in, RAM words and result.
- ACC_W, 18, accumulator width; must hold 4×(2^DW−1)^2 without overflow.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  DW  serial load byte, sampled on rising edges during load.
- trigger  input  1  start request, sampled only in IDLE.
- finished  output  1  high while result carries a valid C element.
- result  output  DW  C element, order C00, C01, C10, C11.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; finished=0; result=0; counters and accumulator=0.
  - RAM contents not cleared; don't-care.
- States: IDLE, LOAD, COMPUTE, OUT.
- IDLE:
  - On an edge with trigger=1: RAM[0]<=data_in, load index=1, go LOAD.
  - trigger=0: stay in IDLE.
- LOAD:
  - Each edge writes RAM[idx]<=data_in and increments idx.
  - After RAM[15] is written (15 edges after the trigger edge), go COMPUTE.
  - trigger is ignored here.
  - data_in must change once per clock; the host drives a new byte each cycle after trigger.
- COMPUTE:
  - One MAC per cycle: acc += A[i][k]*B[k][j], unsigned, ACC_W bits.
  - k runs 0..3; element order (i,j) = (0,0),(0,1),(1,0),(1,1).
  - On the k=3 edge the element is stored into a 4-entry result buffer and acc is cleared.
  - 16 cycles total, then go OUT.
- OUT:
  - 4 cycles. Each cycle finished=1 and result = next buffered element (C00 first).
  - Then return to IDLE with finished=0 and result=0.
- Latency: first edge with trigger=1 is edge 0. finished=1 and result=C00 after edge 32; finished falls after edge 36.
- Arithmetic:
  - Products are 16 bits; the accumulator never overflows at ACC_W=18.
  - Default output conversion is truncation: result = acc[DW-1:0], i.e. mod 256.
- Boundaries:
  - trigger held high continuously: a new load starts only from IDLE, i.e. on the first edge after OUT completes.
  - trigger pulses during LOAD/COMPUTE/OUT: no effect.
  - Reset asserted mid-operation: immediate return to IDLE; partial results discarded; finished drops asynchronously.
  - All-zero data: four zero results with finished framing unchanged.
  - All-0xFF data: each element = 260100, low byte 0x04.

Optional Feature:
- Macro SATURATE_EN.
- Defined: output conversion saturates; result = 2^DW−1 when acc > 2^DW−1, else acc[DW-1:0].
- Undefined: truncation as above.
- Timing and state machine are identical in both builds.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 100 ns, with trigger and data_in toggling.
  - Required: finished=0, result=0, state stays IDLE.
  - Stimulus: release reset with trigger=0.
  - Required: still idle.
- Main load:
  - Stimulus: trigger=1 at the edge with data_in=9, then one byte per clock: 21,105,134,7,3,19,29,14,27,8,20,24,30,40,36.
  - Required (truncation build): finished high edges 32..35 with result 238, 189, 202, 71 (exact sums 8174, 8637, 1738, 1863).
- Same load, SATURATE_EN build -> result 255,255,255,255.
- Identity check:
  - Stimulus: A=[1,0,0,0; 0,1,0,0], B=[5,6; 7,8; 0,0; 0,0].
  - Required: result 5, 6, 7, 8.
- Reset mid-COMPUTE:
  - Stimulus: reset=0 at edge 20, then a fresh full load.
  - Required: no finished before reset; the fresh load yields correct results.
- Trigger held high across a full run:
  - Required: a second load begins on the first edge after OUT ends.
  - Required: trigger pulses during LOAD have no effect (byte count stays 16).
